prog_sequencer: RTL and testbench

Controller that sequences the processor core (top) through up to NUM_PROG stored programs in succession, e.g. multiply, pattern search and minimum pair distance. Per program: holds the core in reset, presents the program's start PC, releases the core, waits for core done, records a cycle count and applies a timeout. Sits beside the core, drives its reset and start-PC inputs, and reports per-program results to the system or bench.

---
 rtl/prog_sequencer.sv | 172 +++++++++++++++++
 tb/tb_prog_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: steps the core through the enabled program slots,
// holding it in reset, timing each run and reporting cycle counts.
module prog_sequencer #(
    parameter int NUM_PROG   = 3,
    parameter int PC_W       = 10,
    parameter int CYC_W      = 16,
    parameter int TIMEOUT    = 60000,
    parameter int RST_CYCLES = 2,
    parameter int IDX_W      = $clog2(NUM_PROG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [NUM_PROG-1:0]      prog_mask,
    input  logic [NUM_PROG*PC_W-1:0] start_pc_flat,
    input  logic                     core_done,
    output logic                     core_reset,
    output logic [PC_W-1:0]          core_start_pc,
    output logic [IDX_W-1:0]         prog_idx,
    output logic                     busy,
    output logic                     cyc_valid,
    output logic [CYC_W-1:0]         cyc_count,
    output logic [IDX_W-1:0]         cyc_idx,
    output logic                     timeout_err,
    output logic                     all_done
);

    localparam int HC_W = $clog2(RST_CYCLES + 1);
    localparam logic [CYC_W-1:0] TMO = CYC_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PROG - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_HOLD,
        S_RUN,
        S_REPORT,
        S_FINISH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [NUM_PROG-1:0] mask_q;
    logic [HC_W-1:0]     hcnt;
    logic [CYC_W-1:0]    cnt;
    logic [PC_W-1:0]     entry [NUM_PROG];
    logic                is_last;
    logic                slot_on;
    logic                hold_end;
    logic                run_tmo;

    for (genvar i = 0; i < NUM_PROG; i++) begin : g_entry
        assign entry[i] = start_pc_flat[i*PC_W +: PC_W];
    end

    assign is_last  = (prog_idx == LAST);
    assign slot_on  = mask_q[prog_idx];
    assign hold_end = (hcnt == HOLD_LAST);
    assign run_tmo  = (cnt == TMO);

    // Moore outputs decoded from the state register only
    assign core_reset = (state != S_RUN);
    assign busy       = (state != S_IDLE);
    assign cyc_valid  = (state == S_REPORT);
    assign all_done   = (state == S_FINISH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nx = S_SELECT;
                end
            end
            S_SELECT: begin
                if (slot_on) begin
                    state_nx = S_HOLD;
                end else if (is_last) begin
                    state_nx = S_FINISH;
                end
            end
            S_HOLD: begin
                if (hold_end) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (core_done || run_tmo) begin
                    state_nx = S_REPORT;
                end
            end
            S_REPORT: begin
                state_nx = is_last ? S_FINISH : S_SELECT;
            end
            S_FINISH: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q        <= '0;
            prog_idx      <= '0;
            core_start_pc <= '0;
            hcnt          <= '0;
            cnt           <= '0;
            cyc_count     <= '0;
            cyc_idx       <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        mask_q      <= prog_mask;
                        prog_idx    <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_SELECT: begin
                    if (slot_on) begin
                        core_start_pc <= entry[prog_idx];
                        hcnt          <= '0;
                    end else if (!is_last) begin
                        prog_idx <= prog_idx + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_end) begin
                        cnt <= CYC_W'(1);
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // done wins over timeout when both land on the same cycle
                    if (core_done) begin
                        cyc_count <= cnt;
                        cyc_idx   <= prog_idx;
                    end else if (run_tmo) begin
                        cyc_count   <= TMO;
                        cyc_idx     <= prog_idx;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (!is_last) begin
                        prog_idx <= prog_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: two sequencers (long and short timeout) checked
// every cycle against a per-program timeline model plus literal results.
module tb_prog_sequencer;

    localparam int RSTC = 2;
    localparam int TMO_A = 60000;
    localparam int TMO_B = 20;

    typedef struct packed {
        logic       busy;
        logic       crst;
        logic [9:0] pc;
        logic [1:0] idx;
        logic       cv;
        logic [15:0] cc;
        logic [1:0] ci;
        logic       terr;
        logic       ad;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [2:0]  prog_mask = 3'b000;
    logic [29:0] start_pc_flat = {10'h080, 10'h040, 10'h000};
    logic        core_done_a = 1'b0;
    logic        core_done_b = 1'b0;

    logic        core_reset_a, core_reset_b;
    logic [9:0]  core_start_pc_a, core_start_pc_b;
    logic [1:0]  prog_idx_a, prog_idx_b;
    logic        busy_a, busy_b;
    logic        cyc_valid_a, cyc_valid_b;
    logic [15:0] cyc_count_a, cyc_count_b;
    logic [1:0]  cyc_idx_a, cyc_idx_b;
    logic        timeout_err_a, timeout_err_b;
    logic        all_done_a, all_done_b;

    int total = 0;
    int bad = 0;

    int lat [2][3];
    int rc_a = 0;
    int rc_b = 0;
    int rec_a [$];
    int rec_b [$];

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t idle_v [2];
    bit   idle_prev [2];
    bit   started = 1'b0;

    always #5 clk = ~clk;

    prog_sequencer u_a (
        .clk(clk), .reset(reset), .go(go),
        .prog_mask(prog_mask), .start_pc_flat(start_pc_flat),
        .core_done(core_done_a), .core_reset(core_reset_a),
        .core_start_pc(core_start_pc_a), .prog_idx(prog_idx_a),
        .busy(busy_a), .cyc_valid(cyc_valid_a),
        .cyc_count(cyc_count_a), .cyc_idx(cyc_idx_a),
        .timeout_err(timeout_err_a), .all_done(all_done_a)
    );

    prog_sequencer #(.TIMEOUT(TMO_B)) u_b (
        .clk(clk), .reset(reset), .go(go),
        .prog_mask(prog_mask), .start_pc_flat(start_pc_flat),
        .core_done(core_done_b), .core_reset(core_reset_b),
        .core_start_pc(core_start_pc_b), .prog_idx(prog_idx_b),
        .busy(busy_b), .cyc_valid(cyc_valid_b),
        .cyc_count(cyc_count_b), .cyc_idx(cyc_idx_b),
        .timeout_err(timeout_err_b), .all_done(all_done_b)
    );

    // core models: done in the lat-th cycle of reset release (0 = never)
    always @(negedge clk) begin
        if (core_reset_a !== 1'b0) begin
            rc_a = 0;
            core_done_a = 1'b0;
        end else begin
            rc_a++;
            core_done_a = (lat[0][prog_idx_a] != 0) &&
                          (rc_a == lat[0][prog_idx_a]);
        end
        if (core_reset_b !== 1'b0) begin
            rc_b = 0;
            core_done_b = 1'b0;
        end else begin
            rc_b++;
            core_done_b = (lat[1][prog_idx_b] != 0) &&
                          (rc_b == lat[1][prog_idx_b]);
        end
        if (cyc_valid_a === 1'b1)
            rec_a.push_back(int'(cyc_idx_a) * 100000 + int'(cyc_count_a));
        if (cyc_valid_b === 1'b1)
            rec_b.push_back(int'(cyc_idx_b) * 100000 + int'(cyc_count_b));
    end

    task automatic push(input int n, input exp_t e);
        if (n == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // expected cycle-by-cycle timeline for a whole accepted sequence
    task automatic build(input int n, input int tmo);
        exp_t e;
        int   l;
        bit   to;
        e = idle_v[n];
        e.busy = 1'b1;
        e.crst = 1'b1;
        e.cv = 1'b0;
        e.ad = 1'b0;
        e.terr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e.idx = 2'(i);
            push(n, e);
            if (prog_mask[i]) begin
                e.pc = start_pc_flat[i*10 +: 10];
                for (int h = 0; h < RSTC; h++) push(n, e);
                to = (lat[n][i] == 0) || (lat[n][i] > tmo);
                l = to ? tmo : lat[n][i];
                e.crst = 1'b0;
                for (int r = 0; r < l; r++) push(n, e);
                e.crst = 1'b1;
                e.cv = 1'b1;
                e.cc = 16'(l);
                e.ci = 2'(i);
                if (to) e.terr = 1'b1;
                push(n, e);
                e.cv = 1'b0;
            end
        end
        e.ad = 1'b1;
        push(n, e);
        e.ad = 1'b0;
        e.busy = 1'b0;
        idle_v[n] = e;
    endtask

    function automatic exp_t got_of(input int n);
        exp_t g;
        if (n == 0)
            g = '{busy_a, core_reset_a, core_start_pc_a, prog_idx_a,
                  cyc_valid_a, cyc_count_a, cyc_idx_a, timeout_err_a,
                  all_done_a};
        else
            g = '{busy_b, core_reset_b, core_start_pc_b, prog_idx_b,
                  cyc_valid_b, cyc_count_b, cyc_idx_b, timeout_err_b,
                  all_done_b};
        return g;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        exp_t g;
        #1;
        if (reset) started = 1'b1;
        if (started) begin
            for (int n = 0; n < 2; n++) begin
                if (reset) begin
                    if (n == 0) q0.delete();
                    else q1.delete();
                    idle_v[n] = '{1'b0, 1'b1, 10'h0, 2'd0, 1'b0,
                                  16'd0, 2'd0, 1'b0, 1'b0};
                    idle_prev[n] = 1'b1;
                    e = idle_v[n];
                end else begin
                    if (go && idle_prev[n])
                        build(n, (n == 0) ? TMO_A : TMO_B);
                    if (n == 0 && q0.size() > 0) begin
                        e = q0.pop_front();
                        idle_prev[n] = 1'b0;
                    end else if (n == 1 && q1.size() > 0) begin
                        e = q1.pop_front();
                        idle_prev[n] = 1'b0;
                    end else begin
                        e = idle_v[n];
                        idle_prev[n] = 1'b1;
                    end
                end
                g = got_of(n);
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL cycle-check dut%0d t=%0t got=%h want=%h",
                             n, $time, g, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic pulse_go(input logic [2:0] m);
        @(negedge clk);
        prog_mask = m;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while ((busy_a || busy_b) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (c >= maxc) chk("wait-idle bound", c, -1);
    endtask

    task automatic chk_rec(input string name, input int n,
                           input int k, input int want);
        int v;
        if (n == 0) v = (rec_a.size() > k) ? rec_a[k] : -1;
        else v = (rec_b.size() > k) ? rec_b[k] : -1;
        chk(name, v, want);
    endtask

    initial begin
        int cnt_n;
        bit found;
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 3; i++) lat[n][i] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset core_reset", int'(core_reset_a), 1);
        chk("reset busy", int'(busy_a), 0);

        // all three slots; dut b times out on slot 0; go repeated while busy
        lat[0] = '{25, 7, 100};
        lat[1] = '{0, 5, 3};
        pulse_go(3'b111);
        repeat (10) @(negedge clk);
        pulse_go(3'b000);
        wait_idle(400);
        chk("t1 a count", rec_a.size(), 3);
        chk_rec("t1 a slot0", 0, 0, 25);
        chk_rec("t1 a slot1", 0, 1, 100007);
        chk_rec("t1 a slot2", 0, 2, 200100);
        chk_rec("t1 b slot0 timeout", 1, 0, 20);
        chk_rec("t1 b slot1", 1, 1, 100005);
        chk("t1 b timeout_err", int'(timeout_err_b), 1);
        chk("t1 a timeout_err", int'(timeout_err_a), 0);
        rec_a.delete();
        rec_b.delete();

        // single middle slot; go clears the sticky error on b
        lat[0] = '{4, 9, 4};
        lat[1] = '{4, 6, 4};
        pulse_go(3'b010);
        wait_idle(100);
        chk("t2 a count", rec_a.size(), 1);
        chk_rec("t2 a slot1", 0, 0, 100009);
        chk_rec("t2 b slot1", 1, 0, 100006);
        chk("t2 b timeout_err", int'(timeout_err_b), 0);
        chk("t2 a pc", int'(core_start_pc_a), 'h040);
        rec_a.delete();
        rec_b.delete();

        // empty mask: all_done on the fourth cycle after the go edge
        @(negedge clk);
        prog_mask = 3'b000;
        go = 1'b1;
        cnt_n = 0;
        found = 1'b0;
        repeat (8) begin
            @(negedge clk);
            go = 1'b0;
            cnt_n++;
            if (all_done_a && !found) begin
                found = 1'b1;
                chk("t3 all_done latency", cnt_n, 4);
            end
        end
        if (!found) chk("t3 all_done seen", 0, 1);
        chk("t3 no reports", rec_a.size(), 0);

        // done in first run cycle; b done exactly at its timeout limit
        lat[0] = '{1, 0, 0};
        lat[1] = '{20, 0, 0};
        pulse_go(3'b001);
        wait_idle(100);
        chk_rec("t4 a first-cycle done", 0, 0, 1);
        chk_rec("t4 b done at limit", 1, 0, 20);
        chk("t4 b timeout_err", int'(timeout_err_b), 0);
        rec_a.delete();
        rec_b.delete();

        // reset in the middle of slot 1, then a clean restart
        lat[0] = '{3, 50, 5};
        lat[1] = '{3, 50, 5};
        pulse_go(3'b111);
        cnt_n = 0;
        while (!(prog_idx_a == 2'd1 && !core_reset_a) && cnt_n < 100) begin
            @(negedge clk);
            cnt_n++;
        end
        if (cnt_n >= 100) chk("t5 reach slot1 run", cnt_n, -1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5 busy after reset", int'(busy_a), 0);
        chk("t5 core_reset after reset", int'(core_reset_a), 1);
        chk("t5 prog_idx after reset", int'(prog_idx_a), 0);
        repeat (5) @(negedge clk);
        rec_a.delete();
        rec_b.delete();
        lat[0] = '{3, 4, 5};
        lat[1] = '{3, 4, 5};
        pulse_go(3'b111);
        wait_idle(100);
        chk("t5 restart count", rec_a.size(), 3);
        chk_rec("t5 restart slot0", 0, 0, 3);
        chk_rec("t5 restart slot2", 0, 2, 200005);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
